// File: rtl/uart_32_bit_transmitter_if.sv
// Word handshake between the register/bus side and the UART transmitter.
// The bus side is the master; the transmitter is the slave.
interface uart_32_bit_transmitter_if;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_32_bit_transmitter.sv
// Serialises one accepted 32-bit word into NUM_BYTES UART frames, LSB byte first.
// All bit timing comes from the upstream baud_tick pulse; clk is never divided here.
module uart_32_bit_transmitter #(
  parameter int NUM_BYTES  = 4,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       baud_tick,
  uart_32_bit_transmitter_if.slave   bus,
  output logic                       tx,
  output logic                       tx_busy,
  output logic                       byte_done
);

  // state  | meaning
  // IDLE   | line high, ready for a word     WAIT  | word latched, waiting first tick
  // START  | start bit on line               DATA  | data bit bit_cnt on line
  // PARITY | parity bit on line              STOP  | stop bit(s) on line
  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_t;

  localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);
  localparam logic [1:0] STOP_LOAD = 2'(STOP_BITS - 1);
  localparam logic       ODD       = (PARITY_ODD != 0);

  state_t      state, state_nxt;
  logic [31:0] word, word_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [1:0]  stop_cnt, stop_cnt_nxt;
  logic        tx_nxt, ready, ready_nxt, busy_nxt, byte_done_nxt;
  logic [7:0]  cur_byte;
  logic [2:0]  bit_inc;
  logic        par_bit;

  assign cur_byte     = word[{byte_cnt, 3'b000} +: 8];
  assign bit_inc      = bit_cnt + 3'd1;
  assign par_bit      = (^cur_byte) ^ ODD;
  assign bus.tx_ready = ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      word      <= '0;
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= '0;
      tx        <= 1'b1;
      ready     <= 1'b1;
      tx_busy   <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      word      <= word_nxt;
      byte_cnt  <= byte_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      stop_cnt  <= stop_cnt_nxt;
      tx        <= tx_nxt;
      ready     <= ready_nxt;
      tx_busy   <= busy_nxt;
      byte_done <= byte_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    word_nxt      = word;
    byte_cnt_nxt  = byte_cnt;
    bit_cnt_nxt   = bit_cnt;
    stop_cnt_nxt  = stop_cnt;
    tx_nxt        = tx;
    ready_nxt     = ready;
    busy_nxt      = tx_busy;
    byte_done_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        tx_nxt    = 1'b1;
        ready_nxt = 1'b1;
        if (bus.tx_valid && ready) begin
          word_nxt     = bus.tx_data;
          byte_cnt_nxt = '0;
          ready_nxt    = 1'b0;
          busy_nxt     = 1'b1;
          state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        tx_nxt = 1'b1;
        if (baud_tick) begin
          tx_nxt    = 1'b0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          tx_nxt      = cur_byte[0];
          bit_cnt_nxt = '0;
          state_nxt   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_cnt != 3'd7) begin
            bit_cnt_nxt = bit_inc;
            tx_nxt      = cur_byte[bit_inc];
          end else if (PARITY_EN != 0) begin
            tx_nxt    = par_bit;
            state_nxt = ST_PARITY;
          end else begin
            tx_nxt       = 1'b1;
            stop_cnt_nxt = STOP_LOAD;
            state_nxt    = ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          tx_nxt       = 1'b1;
          stop_cnt_nxt = STOP_LOAD;
          state_nxt    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (stop_cnt != 2'd0) begin
            stop_cnt_nxt = stop_cnt - 2'd1;
          end else begin
            byte_done_nxt = 1'b1;
            // Next byte starts on this same edge: no idle gap between bytes.
            if (byte_cnt != LAST_BYTE) begin
              byte_cnt_nxt = byte_cnt + 2'd1;
              tx_nxt       = 1'b0;
              state_nxt    = ST_START;
            end else begin
              tx_nxt    = 1'b1;
              ready_nxt = 1'b1;
              busy_nxt  = 1'b0;
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_32_bit_transmitter.sv
// Bench for uart_32_bit_transmitter: four parameterisations, a vector table,
// hand-written corner sequences and random words against a bit-stream model.
module tb_uart_32_bit_transmitter;

  logic clk = 1'b0;
  logic rst;
  logic baud_tick = 1'b0;
  always #5 clk = ~clk;

  uart_32_bit_transmitter_if bus0 ();
  uart_32_bit_transmitter_if bus1 ();
  uart_32_bit_transmitter_if bus2 ();
  uart_32_bit_transmitter_if bus3 ();

  logic tx0, tx1, tx2, tx3;
  logic busy0, busy1, busy2, busy3;
  logic done0, done1, done2, done3;

  uart_32_bit_transmitter #(.NUM_BYTES(4), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(bus0.slave),
    .tx(tx0), .tx_busy(busy0), .byte_done(done0));
  uart_32_bit_transmitter #(.NUM_BYTES(1), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(bus1.slave),
    .tx(tx1), .tx_busy(busy1), .byte_done(done1));
  uart_32_bit_transmitter #(.NUM_BYTES(1), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(bus2.slave),
    .tx(tx2), .tx_busy(busy2), .byte_done(done2));
  uart_32_bit_transmitter #(.NUM_BYTES(4), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0)) dut3 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(bus3.slave),
    .tx(tx3), .tx_busy(busy3), .byte_done(done3));

  int p_nb[4] = '{4, 1, 1, 4};
  int p_pe[4] = '{0, 1, 1, 0};
  int p_po[4] = '{0, 0, 1, 0};
  int p_sb[4] = '{1, 1, 1, 2};

  logic        vld;
  logic [31:0] dat;
  int          sel;

  assign bus0.tx_valid = vld && (sel == 0);
  assign bus1.tx_valid = vld && (sel == 1);
  assign bus2.tx_valid = vld && (sel == 2);
  assign bus3.tx_valid = vld && (sel == 3);
  assign bus0.tx_data  = dat;
  assign bus1.tx_data  = dat;
  assign bus2.tx_data  = dat;
  assign bus3.tx_data  = dat;

  logic tx_m, busy_m, ready_m, done_m;
  always_comb begin
    tx_m = tx0; busy_m = busy0; ready_m = bus0.tx_ready; done_m = done0;
    case (sel)
      1: begin tx_m = tx1; busy_m = busy1; ready_m = bus1.tx_ready; done_m = done1; end
      2: begin tx_m = tx2; busy_m = busy2; ready_m = bus2.tx_ready; done_m = done2; end
      3: begin tx_m = tx3; busy_m = busy3; ready_m = bus3.tx_ready; done_m = done3; end
      default: ;
    endcase
  end

  // Tick generator: tick_div=1 holds baud_tick high every cycle.
  int tick_div = 8;
  int tick_cnt = 0;
  always @(posedge clk) begin
    #1;
    tick_cnt  = (tick_cnt + 1) % tick_div;
    baud_tick = (tick_cnt == 0);
  end

  // Line monitor: one sample of tx per bit period, taken just after each tick edge.
  bit tick_seen = 1'b0;
  bit line_q[$];
  int done_cnt, busy_ticks, busy_cyc, ready_low;
  always @(negedge clk) begin
    if (rst) begin
      if (tick_seen) line_q.push_back(tx_m);
      if (done_m) done_cnt++;
      if (busy_m) busy_cyc++;
      if (!ready_m) ready_low++;
      if (busy_m && baud_tick) busy_ticks++;
    end
    tick_seen = baud_tick;
  end

  int n_checks = 0;
  int n_errors = 0;
  int rd_pos, last_start, last_gap;
  bit exp_q[$];

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic clear_cap();
    line_q.delete();
    done_cnt = 0; busy_ticks = 0; busy_cyc = 0; ready_low = 0;
    rd_pos = 0; last_start = 0; last_gap = 0;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    bit got = 0;
    while (!got && n < 3000) begin
      @(negedge clk);
      n++;
      if (ready_m) got = 1;
    end
    if (!got) chk(1'b0, {name, " accept timeout"}, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input string name);
    dat = w;
    vld = 1'b1;
    wait_accept(name);
    vld = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy_m && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (busy_m) chk(1'b0, {name, " busy timeout"}, 1, 0);
    repeat (2 * tick_div + 3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Reference model: the frame sequence the line must carry for word w.
  task automatic build_exp(input logic [31:0] w);
    logic [7:0] b;
    exp_q.delete();
    for (int k = 0; k < p_nb[sel]; k++) begin
      b = 8'((w >> (8 * k)) & 32'hFF);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
      if (p_pe[sel] != 0) exp_q.push_back(1'(($countones(b) + p_po[sel]) % 2));
      for (int s = 0; s < p_sb[sel]; s++) exp_q.push_back(1'b1);
    end
  endtask

  task automatic check_word(input logic [31:0] w, input string name);
    int p = rd_pos;
    int bad = -1;
    build_exp(w);
    while (p < line_q.size() && line_q[p] != 1'b0) p++;
    last_gap   = p - rd_pos;
    last_start = p;
    if (p + exp_q.size() > line_q.size()) begin
      chk(1'b0, {name, " stream length"}, line_q.size() - p, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (bad < 0 && line_q[p + i] != exp_q[i]) bad = i;
      if (bad >= 0)
        chk(1'b0, {name, " stream bit"}, line_q[p + bad], exp_q[bad]);
      else
        chk(1'b1, {name, " stream"}, 0, 0);
    end
    rd_pos = p + exp_q.size();
  endtask

  typedef struct {
    int          s;
    logic [31:0] w;
    int          div;
    int          exp_done;
    int          exp_ticks;
    int          exp_par;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [31:0] w1, w2;
    int          n;
    tbl[0] = '{0, 32'h44332211, 8, 4, 41, 0};
    tbl[1] = '{1, 32'h000000A5, 8, 1, 12, 0};
    tbl[2] = '{2, 32'h000000A5, 8, 1, 12, 1};
    tbl[3] = '{3, 32'hFFFF0000, 1, 4, 45, 0};
    tbl[4] = '{0, 32'h80C37E01, 3, 4, 41, 0};

    rst = 1'b0; vld = 1'b0; dat = '0; sel = 0;
    repeat (3) @(negedge clk);
    #1;
    chk(tx0 == 1'b1, "reset tx", tx0, 1);
    chk(bus0.tx_ready == 1'b1, "reset ready", bus0.tx_ready, 1);
    chk(busy0 == 1'b0, "reset busy", busy0, 0);
    chk(done0 == 1'b0, "reset byte_done", done0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      sel = tbl[i].s;
      tick_div = tbl[i].div;
      clear_cap();
      send(tbl[i].w, "table");
      wait_idle("table");
      check_word(tbl[i].w, "table");
      chk(done_cnt == tbl[i].exp_done, "table byte_done count", done_cnt, tbl[i].exp_done);
      chk(busy_ticks == tbl[i].exp_ticks, "table busy ticks", busy_ticks, tbl[i].exp_ticks);
      chk(ready_low == busy_cyc, "table ready low vs busy", ready_low, busy_cyc);
      if (tbl[i].div == 1)
        chk(busy_cyc == tbl[i].exp_ticks, "table busy cycles", busy_cyc, tbl[i].exp_ticks);
      else
        chk(busy_cyc > (tbl[i].exp_ticks - 1) * tbl[i].div && busy_cyc <= tbl[i].exp_ticks * tbl[i].div,
            "table busy cycles range", busy_cyc, tbl[i].exp_ticks * tbl[i].div);
      if (p_pe[sel] != 0 && last_start + 9 < line_q.size())
        chk(line_q[last_start + 9] == 1'(tbl[i].exp_par), "table parity bit",
            line_q[last_start + 9], tbl[i].exp_par);
    end

    // Valid held while busy with new data: in-flight word unaffected, new word taken afterwards.
    sel = 0; tick_div = 8;
    @(posedge clk); #1;
    clear_cap();
    w1 = 32'h13579BDF;
    send(w1, "busy ignore");
    n = 0;
    while (done_cnt < 1 && n < 2000) begin @(negedge clk); n++; end
    chk(done_cnt >= 1, "busy ignore reach byte 1", done_cnt, 1);
    @(posedge clk); #1;
    dat = 32'hDEADBEEF;
    vld = 1'b1;
    chk(ready_m == 1'b0, "busy ignore ready low", ready_m, 0);
    wait_accept("busy ignore");
    vld = 1'b0;
    wait_idle("busy ignore");
    check_word(w1, "busy ignore first");
    check_word(32'hDEADBEEF, "busy ignore second");
    chk(last_gap == 1, "busy ignore idle gap", last_gap, 1);

    // Back-to-back with valid held across both words.
    tick_div = 6;
    @(posedge clk); #1;
    clear_cap();
    w1 = $urandom; w2 = $urandom;
    dat = w1; vld = 1'b1;
    wait_accept("b2b first");
    dat = w2;
    wait_accept("b2b second");
    vld = 1'b0;
    wait_idle("b2b");
    check_word(w1, "b2b first");
    check_word(w2, "b2b second");
    chk(last_gap == 1, "b2b idle gap", last_gap, 1);

    // Reset asserted during bit 3 of byte 2.
    tick_div = 8;
    @(posedge clk); #1;
    clear_cap();
    send(32'h12345678, "reset mid");
    n = 0;
    while (done_cnt < 2 && n < 2000) begin @(negedge clk); n++; end
    chk(done_cnt == 2, "reset mid reach byte 2", done_cnt, 2);
    repeat (36) @(negedge clk);
    chk(tx_m == 1'b0, "reset mid bit3 before reset", tx_m, 0);
    rst = 1'b0;
    #1;
    chk(tx_m == 1'b1, "reset mid tx", tx_m, 1);
    chk(ready_m == 1'b1, "reset mid ready", ready_m, 1);
    chk(busy_m == 1'b0, "reset mid busy", busy_m, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    clear_cap();
    send(32'h00000055, "after reset");
    wait_idle("after reset");
    check_word(32'h00000055, "after reset");
    chk(done_cnt == 4, "after reset byte_done count", done_cnt, 4);

    // Random words and tick rates on the 1- and 2-stop-bit configurations.
    for (int k = 0; k < 6; k++) begin
      sel = (k % 2 == 0) ? 0 : 3;
      tick_div = int'($urandom_range(1, 5));
      @(posedge clk); #1;
      clear_cap();
      w1 = $urandom;
      send(w1, "random");
      wait_idle("random");
      check_word(w1, "random");
      chk(done_cnt == 4, "random byte_done count", done_cnt, 4);
      chk(busy_ticks == 1 + 4 * (9 + p_sb[sel]), "random busy ticks", busy_ticks, 1 + 4 * (9 + p_sb[sel]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global timeout: got %0d checks, expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_32_bit_transmitter.md
Name: uart_32_bit_transmitter

Overview:
- Serialises one 32-bit word into NUM_BYTES UART frames, least-significant byte first.
- Each frame is 8 data bits, LSB first, with optional parity.
- Bit timing comes only from the single-cycle baud_tick pulse produced by uart_32_bit_baud_rate directly upstream. The block never divides clk itself.
- Sits between the register/bus side (valid/ready word handshake) and the tx pin.

Parameters:
- NUM_BYTES, 4, bytes sent per accepted word (1..4), taken from tx_data[7:0] upward.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- PARITY_EN, 0, 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0, with PARITY_EN=1: 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  system clock, same domain as the baud generator.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- baud_tick  input  1  one-clk pulse per bit period, from uart_32_bit_baud_rate.
- tx_data  input  32  word to transmit; sampled only on acceptance.
- tx_valid  input  1  word on tx_data is valid.
- tx_ready  output  1  block can accept a word; acceptance = tx_valid & tx_ready at a rising clk edge.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high from acceptance until the last stop bit of the last byte completes.
- byte_done  output  1  one-clk pulse when each byte's final stop bit completes.

Behaviour:
- Reset (rst=0, asynchronous), all outputs registered: tx=1, tx_ready=1, tx_busy=0, byte_done=0, state=IDLE, byte and bit counters=0.
- States: IDLE, WAIT, START, DATA, PARITY, STOP.
- IDLE: tx=1, tx_ready=1.
  - On acceptance: latch tx_data into shift register, byte_cnt=0, tx_ready<=0, tx_busy<=1, go to WAIT.
- WAIT: hold tx=1.
  - On the first baud_tick after acceptance: tx<=0, go to START.
  - A baud_tick coincident with the acceptance edge is not used; only ticks sampled in WAIT count.
- Advancement rule: every later transition happens only on a clk edge where baud_tick=1. tx changes in the cycle after the tick is sampled.
- START: on tick, tx<=shift[0], bit_cnt=0, go to DATA.
- DATA: on tick, if bit_cnt<7, shift right, tx<=next bit, bit_cnt+1.
  - After bit 7: go to PARITY if PARITY_EN, else go to STOP with tx<=1.
- PARITY:
  - The parity bit is driven on the tick that ends bit 7.
  - Even parity: tx = XOR of the 8 bits. Odd parity: inverted XOR.
  - The next tick goes to STOP with tx<=1.
- STOP: hold tx=1 for STOP_BITS tick periods. On the tick that ends the last stop bit, pulse byte_done for one cycle, then:
  - if byte_cnt<NUM_BYTES-1: byte_cnt+1, load the next byte, tx<=0, go to START. Bytes are back-to-back with no idle gap.
  - else: go to IDLE, tx_ready<=1, tx_busy<=0 on that same edge.
- Frame length: (1+8+PARITY_EN+STOP_BITS) tick periods per byte. Total word time = NUM_BYTES × frame length, plus the WAIT interval before the first tick.
- tx_valid while tx_ready=0 is ignored; the word is not queued, and tx_data changes mid-frame have no effect.
- baud_tick held high every cycle: one bit per clk. This must still work, with no skipped or duplicated bits.
- Reset asserted mid-frame: immediate return to the reset values. tx returns high within the reset, with no partial stop bit.
- Back-to-back words: the next word can be accepted in the first IDLE cycle. Its start bit begins on the next tick, giving at least one clk and at most one bit period of idle high.

Test Plan:
- Basic word: tick every 8 clk, defaults, tx_data=0x44332211, one valid pulse.
  - Decode tx into bytes 0x11, 0x22, 0x33, 0x44, each start=0 and stop=1.
  - 40 bit periods total; byte_done pulses 4 times; tx_ready is low exactly 40 tick periods (plus WAIT) and then returns to 1.
- Parity: PARITY_EN=1, PARITY_ODD=0, tx_data=0x000000A5, NUM_BYTES=1.
  - Frame is 0, 1,0,1,0,0,1,0,1, parity=0, 1.
  - Repeat with PARITY_ODD=1: parity bit=1.
- Continuous tick (baud_tick=1), STOP_BITS=2, tx_data=0xFFFF0000 → each bit lasts exactly 1 clk; 44 clk of frame data; bytes 0x00, 0x00, 0xFF, 0xFF.
- Busy ignore: during byte 1, drive tx_valid=1 with tx_data=0xDEADBEEF.
  - The in-flight word completes unchanged.
  - tx_ready rises, and 0xDEADBEEF is accepted then (valid is still high) and sent as EF, BE, AD, DE.
- Reset mid-frame: rst=0 during bit 3 of byte 2 → same cycle: tx=1, tx_ready=1, tx_busy=0. After release, a new word 0x00000055 transmits cleanly.
- Back-to-back: hold tx_valid=1 across two words → the inter-word idle gap is ≤1 bit period and ≥1 clk, and both words decode correctly.
